board_ram_write_ctrl: RTL
=========================

BOARD_RAM_WRITE_CTRL -- requirements
Module: board_ram_write_ctrl

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 7, width of a RAM word.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 9, RAM address width (depth 2**ADDR_WIDTH).
REQ-003 The module SHALL have parameter CLEAR_VALUE, default 0, word written by the clear sweep.
REQ-004 The module SHALL have port clk_i  input  1  single clock; every register updates on its rising edge.
REQ-005 The module SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-006 The module SHALL have port clear_start_i  input  1  request a full-memory clear sweep.
REQ-007 The module SHALL have port clear_busy_o  output  1  sweep in progress.
REQ-008 The module SHALL have port clear_done_o  output  1  one-cycle pulse marking the final sweep write.
REQ-009 The module SHALL have port a_valid_i  input  1  requester A (game logic) write request.
REQ-010 The module SHALL have ports a_addr_i  input  ADDR_WIDTH and a_data_i  input  DATA_WIDTH, requester A address and data.
REQ-011 The module SHALL have port a_ready_o  output  1  requester A accepted this cycle.
REQ-012 The module SHALL have ports b_valid_i  input  1, b_addr_i  input  ADDR_WIDTH, b_data_i  input  DATA_WIDTH and b_ready_o  output  1, for requester B (cursor/overlay), with the same meanings as A.
REQ-013 The module SHALL have ports ram_we_o  output  1, ram_waddr_o  output  ADDR_WIDTH and ram_wdata_o  output  DATA_WIDTH, driving the RAM write port.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE (serve requesters) and CLEAR (sweep).
REQ-015 A transfer SHALL occur when x_valid_i and x_ready_o are both 1 on a rising edge.
REQ-016 x_ready_o SHALL be combinational from the state, the valids, clear_start_i and the priority pointer.
REQ-017 A requester SHALL hold valid, addr and data stable until accepted; the block is not required to tolerate violations.
REQ-018 In IDLE with clear_start_i=0, if only one valid is 1, that requester's ready SHALL be 1.
REQ-019 In IDLE with clear_start_i=0 and both valids 1, ready SHALL go to the requester the pointer favours; the other requester's ready SHALL be 0.
REQ-020 After each transfer, the pointer SHALL favour the requester that did not transfer; when there is no transfer, the pointer SHALL be unchanged.
REQ-021 An accepted write SHALL appear one cycle later: ram_we_o=1 with the registered address and data; otherwise ram_we_o=0.
REQ-022 ram_waddr_o and ram_wdata_o SHALL hold their last values while ram_we_o=0.
REQ-023 At most one RAM write SHALL be issued per cycle.
REQ-024 In IDLE, clear_start_i=1 SHALL force both readies to 0 that cycle; the next state is CLEAR, the sweep counter is 0, and clear_busy_o=1 from the next cycle.
REQ-025 In CLEAR, each edge SHALL register ram_we_o=1, ram_waddr_o=counter and ram_wdata_o=CLEAR_VALUE, then increment the counter.
REQ-026 The 2**ADDR_WIDTH sweep writes SHALL be issued on consecutive cycles with addresses 0 .. 2**ADDR_WIDTH-1, ascending, with no gaps.
REQ-027 On the edge that registers the final address (all ones), the state SHALL return to IDLE, clear_busy_o SHALL go to 0, and clear_done_o SHALL go to 1 for exactly that one cycle, coinciding with the final write.
REQ-028 The sweep counter SHALL NOT wrap into a second sweep.
REQ-029 In CLEAR, both readies SHALL be 0 and clear_start_i SHALL be ignored.
REQ-030 A held requester SHALL be served in IDLE after the sweep ends, following REQ-018 and REQ-019.
REQ-031 clear_start_i held high across the end of a sweep SHALL start a new sweep, sampled in the first IDLE cycle.

Reset
REQ-032 When rst_ni=0 at an edge, the state SHALL be IDLE, the counter 0, the pointer favouring A, and ram_we_o, clear_busy_o and clear_done_o SHALL be 0.
REQ-033 While rst_ni=0, ram_waddr_o and ram_wdata_o SHALL be 0.
REQ-034 While rst_ni=0, a_ready_o and b_ready_o SHALL be 0.
REQ-035 Reset during CLEAR SHALL abandon the sweep with no clear_done_o pulse, and no write SHALL be issued on the cycle after the reset edge.

Verification
REQ-036 The bench SHALL cover: A only, addr 5, data 0x2A -> a_ready_o=1; next cycle ram_we_o=1, ram_waddr_o=5, ram_wdata_o=0x2A.
REQ-037 The bench SHALL cover: A and B held valid for 4 cycles after reset -> grant order A, B, A, B, with four writes on consecutive cycles.
REQ-038 The bench SHALL cover: clear_start_i pulse, ADDR_WIDTH=9 -> 512 writes of 0 to addresses 0..511; clear_busy_o high for 512 cycles; clear_done_o high only together with address 511.
REQ-039 The bench SHALL cover: A valid during a sweep -> a_ready_o=0 throughout; accepted in the first IDLE cycle; its write lands after address 511.
REQ-040 The bench SHALL cover: clear_start_i and A valid in the same IDLE cycle -> A is not accepted; the sweep starts; A is served after the sweep.
REQ-041 The bench SHALL cover: rst_ni=0 at sweep address 100 -> the next cycle has ram_we_o=0 and clear_busy_o=0; no clear_done_o pulse; after release, A is served immediately.

Source files
------------

// File: rtl/board_ram_write_ctrl.sv
// Write-port arbiter for the board RAM: round-robin between two requesters,
// plus a full-memory clear sweep that owns the port while it runs.
module board_ram_write_ctrl #(
  parameter int                    DATA_WIDTH  = 7,
  parameter int                    ADDR_WIDTH  = 9,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_start_i,
  output logic                  clear_busy_o,
  output logic                  clear_done_o,
  input  logic                  a_valid_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  output logic                  a_ready_o,
  input  logic                  b_valid_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  output logic                  b_ready_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_waddr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                state_p0, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt_p0;
  logic                  fav_b_p0;
  logic                  cnt_last;
  logic                  a_rdy, b_rdy;

  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] waddr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;
  logic                  done_p1;

  assign cnt_last = &cnt_p0;

  always_comb begin
    state_nxt = state_p0;
    a_rdy     = 1'b0;
    b_rdy     = 1'b0;
    case (state_p0)
      IDLE: begin
        if (clear_start_i) begin
          state_nxt = CLEAR;
        end else if (a_valid_i && (!b_valid_i || !fav_b_p0)) begin
          a_rdy = 1'b1;
        end else if (b_valid_i) begin
          b_rdy = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Readies are forced low combinationally while reset is held.
  assign a_ready_o = a_rdy & rst_ni;
  assign b_ready_o = b_rdy & rst_ni;

  // Stage p0 -> p1: registered RAM write port and sweep bookkeeping
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      fav_b_p0 <= 1'b0;
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      done_p1  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      vld_p1   <= 1'b0;
      done_p1  <= 1'b0;
      if (state_p0 == CLEAR) begin
        vld_p1   <= 1'b1;
        waddr_p1 <= cnt_p0;
        wdata_p1 <= CLEAR_VALUE;
        done_p1  <= cnt_last;
        // Return to zero on the last address so a new sweep always starts clean.
        cnt_p0   <= cnt_last ? '0 : cnt_p0 + ADDR_WIDTH'(1);
      end else begin
        cnt_p0 <= '0;
        if (a_rdy) begin
          vld_p1   <= 1'b1;
          waddr_p1 <= a_addr_i;
          wdata_p1 <= a_data_i;
          fav_b_p0 <= 1'b1;
        end else if (b_rdy) begin
          vld_p1   <= 1'b1;
          waddr_p1 <= b_addr_i;
          wdata_p1 <= b_data_i;
          fav_b_p0 <= 1'b0;
        end
      end
    end
  end

  assign ram_we_o     = vld_p1;
  assign ram_waddr_o  = waddr_p1;
  assign ram_wdata_o  = wdata_p1;
  assign clear_done_o = done_p1;
  assign clear_busy_o = (state_p0 == CLEAR);

endmodule
